// File: rtl/host_avg_pkg.sv
// Shared constants and FSM state type for the host-side averager poller.
package host_avg_pkg;

  localparam int unsigned AVG_W   = 24;
  localparam int unsigned NPT_W   = 8;
  localparam int unsigned NPT_MAX = 255;

  localparam int unsigned FLAG_EMPTY = 0;
  localparam int unsigned FLAG_SAT   = 1;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StStrobe,
    StWait,
    StLatch
  } state_e;

endpackage

// File: rtl/host_avg_fifo.sv
// Synchronous show-ahead FIFO built as a shift queue; entry 0 is the registered head.
module host_avg_fifo #(
  parameter int unsigned WIDTH   = 34,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [FIFO_AW-1:0] wr_idx;
  logic               do_pop, do_push;

  assign full    = (cnt_q == (FIFO_AW + 1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full queue still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign wr_idx  = do_pop ? cnt_q[FIFO_AW-1:0] - FIFO_AW'(1) : cnt_q[FIFO_AW-1:0];
  assign rdata   = mem_q[0];

  always_comb begin
    mem_d = mem_q;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[DEPTH-1] = '0;
    end
    if (do_push) begin
      mem_d[wr_idx] = wdata;
    end
    cnt_d = cnt_q + (FIFO_AW + 1)'(do_push) - (FIFO_AW + 1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/host_avg_poller.sv
// Periodic read-strobe poller for host_averager with classified, queued captures.
// Optional feature: HOST_AVG_POLLER_TAG_EN enables per-entry sequence tags on rec_seq.
module host_avg_poller
  import host_avg_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned LATENCY  = 1,
  parameter int unsigned FIFO_AW  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [31:0]         avg_word,
  output logic                read_s,
  output logic [31:0]         rec_data,
  output logic [1:0]          rec_flags,
  output logic [7:0]          rec_seq,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic [15:0]         drop_cnt,
  output logic [15:0]         sat_cnt
);

  localparam logic [PERIOD_W-1:0] LatW      = PERIOD_W'(LATENCY);
  localparam logic [PERIOD_W-1:0] MinPeriod = PERIOD_W'(4);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, lim_q, lim_d, lim_new;
  logic                read_s_q, latch;
  logic [NPT_W-1:0]    npt;
  logic [1:0]          flags;
  logic [31:0]         cap_word;
  logic                fifo_full, fifo_empty, pop, drop;
  logic [15:0]         drop_q, sat_q;

  assign lim_new = (period < MinPeriod) ? MinPeriod - PERIOD_W'(2) : period - PERIOD_W'(2);

  // After LATCH the counter resumes at LATENCY so the strobe-to-strobe interval stays
  // exactly max(period,4) regardless of the readout latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    latch   = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StCount;
          cnt_d   = '0;
          lim_d   = lim_new;
        end
        StCount: begin
          if (cnt_q >= lim_q) state_d = StStrobe;
          else                cnt_d   = cnt_q + PERIOD_W'(1);
        end
        StStrobe: begin
          cnt_d   = '0;
          state_d = (LATENCY > 1) ? StWait : StLatch;
        end
        StWait: begin
          if (cnt_q + PERIOD_W'(2) >= LatW) state_d = StLatch;
          else                              cnt_d   = cnt_q + PERIOD_W'(1);
        end
        StLatch: begin
          latch   = 1'b1;
          cnt_d   = LatW;
          lim_d   = lim_new;
          state_d = (LatW > lim_new) ? StStrobe : StCount;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      lim_q    <= '0;
      read_s_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lim_q    <= lim_d;
      read_s_q <= (state_d == StStrobe);
    end
  end

  assign read_s   = read_s_q;
  assign npt      = avg_word[NPT_W-1:0];
  assign cap_word = {avg_word[NPT_W +: AVG_W], npt};
  assign flags[FLAG_EMPTY] = (npt == '0);
  assign flags[FLAG_SAT]   = (npt == NPT_W'(NPT_MAX));

  assign rec_valid = !fifo_empty;
  assign pop       = rec_valid && rec_ready;
  assign drop      = latch && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      sat_q  <= '0;
    end else begin
      if (drop && drop_q != 16'hffff) drop_q <= drop_q + 16'd1;
      if (latch && flags[FLAG_SAT] && sat_q != 16'hffff) sat_q <= sat_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
  assign sat_cnt  = sat_q;

`ifdef HOST_AVG_POLLER_TAG_EN
  localparam int unsigned RecW = 42;
`else
  localparam int unsigned RecW = 34;
`endif

  logic [RecW-1:0] wdata, rdata;

`ifdef HOST_AVG_POLLER_TAG_EN
  logic [7:0] seq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     seq_q <= '0;
    else if (latch) seq_q <= seq_q + 8'd1;
  end

  assign wdata   = {seq_q, flags, cap_word};
  assign rec_seq = rdata[RecW-1 -: 8];
`else
  assign wdata   = {flags, cap_word};
  assign rec_seq = '0;
`endif

  assign rec_data  = rdata[31:0];
  assign rec_flags = rdata[33:32];

  host_avg_fifo #(
    .WIDTH   (RecW),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (latch),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_host_avg_poller.sv
// Self-checking bench for host_avg_poller against a transaction-level queue model.
module tb_host_avg_poller;

  localparam int unsigned PW    = 16;
  localparam int unsigned LAT   = 1;
  localparam int unsigned AW    = 3;
  localparam int          DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n, enable, rec_ready, read_s, rec_valid;
  logic [PW-1:0] period;
  logic [31:0]   avg_word, rec_data;
  logic [1:0]    rec_flags;
  logic [7:0]    rec_seq;
  logic [15:0]   drop_cnt, sat_cnt;

  host_avg_poller #(
    .PERIOD_W (PW),
    .LATENCY  (LAT),
    .FIFO_AW  (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .period    (period),
    .avg_word  (avg_word),
    .read_s    (read_s),
    .rec_data  (rec_data),
    .rec_flags (rec_flags),
    .rec_seq   (rec_seq),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .drop_cnt  (drop_cnt),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  flags;
    logic [7:0]  seq;
  } rec_t;

  rec_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          next_strobe = -1;
  int          latch_at = -1;
  int          n_lat = 0;
  bit          active = 1'b0;
  logic [7:0]  m_seq;
  logic [15:0] m_drop, m_sat;
  int          word_mode = 0;
  logic [31:0] const_word;

  function automatic int peff(input int p);
    return (p < 4) ? 4 : p;
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0:       w[7:0] = 8'h00;
      1:       w[7:0] = 8'hff;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    active      = 1'b0;
    next_strobe = -1;
    latch_at    = -1;
    m_seq       = '0;
    m_drop      = '0;
    m_sat       = '0;
  endtask

  task automatic check_reset_vals();
    chk("rst_read_s", read_s, 1'b0);
    chk("rst_rec_valid", rec_valid, 1'b0);
    chk("rst_rec_data", rec_data, 32'h0);
    chk("rst_rec_flags", rec_flags, 2'b00);
    chk("rst_rec_seq", rec_seq, 8'h00);
    chk("rst_drop_cnt", drop_cnt, 16'h0);
    chk("rst_sat_cnt", sat_cnt, 16'h0);
  endtask

  // One clock cycle: drive inputs, compare outputs, then advance the model over the edge.
  task automatic step(input bit en, input bit rdy);
    rec_t        r;
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    w         = (word_mode == 0) ? const_word : gen_word();
    enable    = en;
    rec_ready = rdy;
    avg_word  = w;
    chk("read_s", read_s, active && (cyc == next_strobe));
    chk("rec_valid", rec_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("rec_data", rec_data, q[0].data);
      chk("rec_flags", rec_flags, q[0].flags);
      chk("rec_seq", rec_seq, q[0].seq);
    end
    chk("drop_cnt", drop_cnt, m_drop);
    chk("sat_cnt", sat_cnt, m_sat);
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (!en) begin
      active   = 1'b0;
      latch_at = -1;
    end else if (!active) begin
      active      = 1'b1;
      next_strobe = cyc + peff(int'(period));
    end else begin
      if (cyc == latch_at) begin
        n_lat++;
        r.data  = w;
        r.flags = {w[7:0] == 8'hff, w[7:0] == 8'h00};
`ifdef HOST_AVG_POLLER_TAG_EN
        r.seq   = m_seq;
`else
        r.seq   = 8'h00;
`endif
        if (w[7:0] == 8'hff && m_sat != 16'hffff) m_sat++;
        if (q.size() < DEPTH) q.push_back(r);
        else if (m_drop != 16'hffff) m_drop++;
        m_seq++;
        next_strobe = cyc - LAT + peff(int'(period));
        latch_at    = -1;
      end
      if (cyc == next_strobe) latch_at = cyc + LAT;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy);
  endtask

  // rmode: 0 = never ready, 1 = always ready, 2 = random ready
  task automatic run_polls(input int n, input int rmode);
    int target, budget;
    bit rdy;
    target = n_lat + n;
    budget = n * (peff(int'(period)) + 4) + 8;
    while (n_lat < target && budget > 0) begin
      rdy = (rmode == 2) ? bit'($urandom_range(0, 1)) : (rmode == 1);
      step(1'b1, rdy);
      budget--;
    end
    chk("poll_budget", n_lat, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sat0;
    int          budget;
    rst_n      = 1'b0;
    enable     = 1'b0;
    rec_ready  = 1'b0;
    period     = 16'd20;
    avg_word   = '0;
    const_word = 32'h015B3805;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    // Basic poll rate with a constant averager word
    idle(2, 1'b1);
    word_mode = 0;
    run_polls(3, 1);

    // Period clamp
    idle(2, 1'b1);
    period = 16'd2;
    run_polls(5, 1);

    // Empty flag
    idle(2, 1'b1);
    period     = 16'd6;
    const_word = 32'h00ABCD00;
    run_polls(2, 1);

    // Saturation on three polls
    const_word = 32'h123456FF;
    sat0       = m_sat;
    run_polls(3, 1);
    step(1'b1, 1'b1);
    chk("sat_cnt_plus3", sat_cnt, sat0 + 16'd3);

    // Abort: drop enable the cycle after read_s
    idle(2, 1'b1);
    word_mode = 1;
    period    = 16'd8;
    budget    = 40;
    while (latch_at == -1 && budget > 0) begin
      step(1'b1, 1'b1);
      budget--;
    end
    chk("abort_strobe_seen", latch_at != -1, 1'b1);
    step(1'b0, 1'b1);
    idle(3, 1'b1);
    run_polls(2, 1);

    // Randomized words, periods and host back-pressure
    idle(2, 1'b1);
    period = 16'(4 + $urandom_range(0, 8));
    run_polls(30, 2);

    // Asynchronous reset with four entries queued
    idle(12, 1'b1);
    period = 16'd4;
    run_polls(4, 0);
    @(negedge clk);
    chk("pre_reset_valid", rec_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    enable = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Overflow: ten polls with no pops
    idle(2, 1'b0);
    period = 16'd4;
    run_polls(10, 0);
    step(1'b0, 1'b0);
    chk("ovf_drop_cnt", drop_cnt, 16'd2);
    chk("ovf_valid", rec_valid, 1'b1);
    idle(10, 1'b1);
    run_polls(1, 1);
    idle(3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
